// File: rtl/sample_stream_feeder.sv
// Feeds a processor input FIFO from a sample ROM: power-up wait, processor reset pulse,
// then rate-limited streaming with stall or drop-and-count backpressure handling.
module sample_stream_feeder #(
    parameter int    DATA_W    = 16,
    parameter int    DEPTH     = 640,
    parameter int    ADDR_W    = 10,
    parameter string MEM_FILE  = "sinal_harm_q.mif",
    parameter int    RST_WAIT  = 16383,
    parameter int    RST_LEN   = 1,
    parameter int    RATE_DIV  = 1,
    parameter int    DROP_MODE = 0,
    parameter int    CNT_W     = 16,
    // ROM contents; word i sits at bits [i*DATA_W +: DATA_W]
    parameter logic [DEPTH*DATA_W-1:0] INIT_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_geral,
    input  logic              loop_en,
    input  logic              pause,
    input  logic              full,
    output logic              rst_proc,
    output logic [DATA_W-1:0] data,
    output logic              wrreq,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int WAIT_W = $clog2(RST_WAIT + RST_LEN + 1);
    localparam int RATE_W = $clog2(RATE_DIV) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RST_WAIT - 1);
    localparam logic [WAIT_W-1:0] LEN_LAST  = WAIT_W'(RST_LEN - 1);
    localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RATE_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam bit                DROP_EN   = (DROP_MODE != 0);

    typedef enum logic [1:0] {StWait, StPrst, StStream, StDone} state_e;

    state_e            state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [RATE_W-1:0] rate_cnt_q;
    logic [DATA_W-1:0] rom_word;

    assign rom_word = INIT_DATA[int'(addr)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst_geral) begin
            state_q    <= StWait;
            wait_cnt_q <= '0;
            rate_cnt_q <= '0;
            addr       <= '0;
            data       <= '0;
            wrreq      <= 1'b0;
            rst_proc   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sent_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            wrreq <= 1'b0;
            case (state_q)
                StWait: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q    <= StPrst;
                        rst_proc   <= 1'b1;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                StPrst: begin
                    if (wait_cnt_q == LEN_LAST) begin
                        state_q    <= StStream;
                        rst_proc   <= 1'b0;
                        busy       <= 1'b1;
                        rate_cnt_q <= '0;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                StStream: begin
                    // In stall mode a full FIFO leaves rate_cnt at terminal so the slot stays pending
                    if (!pause) begin
                        if (rate_cnt_q != RATE_LAST) begin
                            rate_cnt_q <= rate_cnt_q + RATE_W'(1);
                        end else if (!full || DROP_EN) begin
                            rate_cnt_q <= '0;
                            if (!full) begin
                                data  <= rom_word;
                                wrreq <= 1'b1;
                                if (sent_cnt != CNT_MAX) sent_cnt <= sent_cnt + CNT_W'(1);
                            end else if (drop_cnt != CNT_MAX) begin
                                drop_cnt <= drop_cnt + CNT_W'(1);
                            end
                            if (addr == ADDR_LAST) begin
                                addr <= '0;
                                if (!loop_en) begin
                                    state_q <= StDone;
                                    busy    <= 1'b0;
                                    done    <= 1'b1;
                                end
                            end else begin
                                addr <= addr + ADDR_W'(1);
                            end
                        end
                    end
                end
                StDone: begin
                end
                default: state_q <= StWait;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_stream_feeder.sv
// Bench for sample_stream_feeder: three configurations driven by shared inputs, checked
// against a slot-level reference model, directed vector tables and random traffic.
module tb_sample_stream_feeder;

    localparam int DW  = 16;
    localparam int DEP = 4;
    localparam int AW  = 2;
    localparam int RW  = 8;
    localparam int RL  = 2;
    localparam logic [DEP*DW-1:0] INIT = {16'h8000, 16'h0007, 16'hFFFD, 16'h0005};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, loop_en = 1'b0, pause = 1'b0, full = 1'b0;

    logic          a_rp, a_wr, a_busy, a_done;
    logic [DW-1:0] a_data;
    logic [AW-1:0] a_addr;
    logic [15:0]   a_sent, a_drop;
    logic          b_rp, b_wr, b_busy, b_done;
    logic [DW-1:0] b_data;
    logic [AW-1:0] b_addr;
    logic [15:0]   b_sent, b_drop;
    logic          c_rp, c_wr, c_busy, c_done;
    logic [DW-1:0] c_data;
    logic [AW-1:0] c_addr;
    logic [2:0]    c_sent, c_drop;

    sample_stream_feeder #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .MEM_FILE(""),
        .RST_WAIT(RW), .RST_LEN(RL), .RATE_DIV(1), .DROP_MODE(0), .CNT_W(16),
        .INIT_DATA(INIT)) dut_a (
        .clk(clk), .rst_geral(rst), .loop_en(loop_en), .pause(pause), .full(full),
        .rst_proc(a_rp), .data(a_data), .wrreq(a_wr), .addr(a_addr), .busy(a_busy),
        .done(a_done), .sent_cnt(a_sent), .drop_cnt(a_drop));

    sample_stream_feeder #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .MEM_FILE(""),
        .RST_WAIT(RW), .RST_LEN(RL), .RATE_DIV(3), .DROP_MODE(0), .CNT_W(16),
        .INIT_DATA(INIT)) dut_b (
        .clk(clk), .rst_geral(rst), .loop_en(loop_en), .pause(pause), .full(full),
        .rst_proc(b_rp), .data(b_data), .wrreq(b_wr), .addr(b_addr), .busy(b_busy),
        .done(b_done), .sent_cnt(b_sent), .drop_cnt(b_drop));

    sample_stream_feeder #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .MEM_FILE(""),
        .RST_WAIT(RW), .RST_LEN(RL), .RATE_DIV(1), .DROP_MODE(1), .CNT_W(3),
        .INIT_DATA(INIT)) dut_c (
        .clk(clk), .rst_geral(rst), .loop_en(loop_en), .pause(pause), .full(full),
        .rst_proc(c_rp), .data(c_data), .wrreq(c_wr), .addr(c_addr), .busy(c_busy),
        .done(c_done), .sent_cnt(c_sent), .drop_cnt(c_drop));

    int total = 0;
    int bad   = 0;

    // Reference model: elapsed cycles since release, slot progress, sample index, tallies
    logic [15:0] mem [DEP] = '{16'h0005, 16'hFFFD, 16'h0007, 16'h8000};
    int rd_k [3] = '{1, 3, 1};
    int dm_k [3] = '{0, 0, 1};
    int mx_k [3] = '{65535, 65535, 7};
    int m_t [3], m_ph [3], m_idx [3], m_sent [3], m_drop [3];
    bit m_done [3], m_wr [3];
    logic [15:0] m_dat [3];

    typedef struct {
        int          e;
        logic        rp, busy, wr, done;
        logic [15:0] dat;
        int          sent;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input int k);
        m_wr[k] = 1'b0;
        if (rst) begin
            m_t[k] = 0; m_ph[k] = 0; m_idx[k] = 0; m_sent[k] = 0; m_drop[k] = 0;
            m_done[k] = 1'b0; m_dat[k] = '0;
        end else if (m_done[k]) begin
        end else if (m_t[k] < RW + RL) begin
            m_t[k]++;
        end else if (!pause) begin
            if (m_ph[k] < rd_k[k] - 1) begin
                m_ph[k]++;
            end else if (!full || dm_k[k] != 0) begin
                if (!full) begin
                    m_wr[k]  = 1'b1;
                    m_dat[k] = mem[m_idx[k]];
                    if (m_sent[k] < mx_k[k]) m_sent[k]++;
                end else if (m_drop[k] < mx_k[k]) begin
                    m_drop[k]++;
                end
                m_ph[k] = 0;
                m_idx[k]++;
                if (m_idx[k] == DEP) begin
                    m_idx[k] = 0;
                    if (!loop_en) m_done[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_dut(input int k);
        logic [31:0] rp, wr, bs, dn, dt, ad, sn, dr;
        case (k)
            0: begin rp = a_rp; wr = a_wr; bs = a_busy; dn = a_done; dt = a_data;
                     ad = a_addr; sn = a_sent; dr = a_drop; end
            1: begin rp = b_rp; wr = b_wr; bs = b_busy; dn = b_done; dt = b_data;
                     ad = b_addr; sn = b_sent; dr = b_drop; end
            default: begin rp = c_rp; wr = c_wr; bs = c_busy; dn = c_done; dt = c_data;
                     ad = c_addr; sn = c_sent; dr = c_drop; end
        endcase
        check($sformatf("dut%0d.rst_proc", k), rp,
              32'(!m_done[k] && m_t[k] >= RW && m_t[k] < RW + RL));
        check($sformatf("dut%0d.busy", k), bs, 32'(!m_done[k] && m_t[k] >= RW + RL));
        check($sformatf("dut%0d.done", k), dn, 32'(m_done[k]));
        check($sformatf("dut%0d.wrreq", k), wr, 32'(m_wr[k]));
        check($sformatf("dut%0d.data", k), dt, 32'(m_dat[k]));
        check($sformatf("dut%0d.addr", k), ad, m_idx[k]);
        check($sformatf("dut%0d.sent_cnt", k), sn, m_sent[k]);
        check($sformatf("dut%0d.drop_cnt", k), dr, m_drop[k]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) model_edge(k);
        for (int k = 0; k < 3; k++) check_dut(k);
    endtask

    task automatic restart(input logic lp);
        rst = 1'b1;
        full = 1'b0;
        pause = 1'b0;
        loop_en = lp;
        step();
        rst = 1'b0;
        for (int i = 0; i < RW + RL; i++) step();
    endtask

    initial begin
        tbl[0] = '{7,  1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0};
        tbl[1] = '{8,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 0};
        tbl[2] = '{9,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 0};
        tbl[3] = '{10, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 0};
        tbl[4] = '{11, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0005, 1};
        tbl[5] = '{12, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFD, 2};
        tbl[6] = '{13, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0007, 3};
        tbl[7] = '{14, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8000, 4};
        tbl[8] = '{15, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8000, 4};
        tbl[9] = '{18, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8000, 4};

        // Reset state, then sequencing and one-shot playback on the RATE_DIV=1 stall instance
        step();
        step();
        check("reset.rst_proc", a_rp, 0);
        check("reset.addr", a_addr, 0);
        check("reset.data", a_data, 0);
        rst = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            step();
            foreach (tbl[i]) begin
                if (tbl[i].e == e) begin
                    check($sformatf("seq%0d.rst_proc", e), a_rp, 32'(tbl[i].rp));
                    check($sformatf("seq%0d.busy", e), a_busy, 32'(tbl[i].busy));
                    check($sformatf("seq%0d.wrreq", e), a_wr, 32'(tbl[i].wr));
                    check($sformatf("seq%0d.done", e), a_done, 32'(tbl[i].done));
                    check($sformatf("seq%0d.data", e), a_data, 32'(tbl[i].dat));
                    check($sformatf("seq%0d.sent", e), a_sent, tbl[i].sent);
                end
            end
        end

        // Rate and loop: 24 stream cycles at RATE_DIV=3 give 8 samples, two full passes
        restart(1'b1);
        for (int i = 0; i < 24; i++) step();
        check("loop.sent_cnt", b_sent, 8);
        check("loop.addr", b_addr, 0);
        check("loop.data", b_data, 16'h8000);

        // Stall: full across the first slot holds sample 0 until full drops
        restart(1'b0);
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall.wrreq_while_full", a_wr, 0);
        end
        full = 1'b0;
        step();
        check("stall.wrreq_release", a_wr, 1);
        check("stall.data_release", a_data, 16'h0005);
        check("stall.drop_cnt", a_drop, 0);

        // Drop: two slots lost to full, remaining two samples written
        restart(1'b0);
        full = 1'b1;
        step();
        step();
        full = 1'b0;
        step();
        step();
        check("drop.drop_cnt", c_drop, 2);
        check("drop.sent_plus_drop", 32'(c_sent) + 32'(c_drop), DEP);
        check("drop.done", c_done, 1);
        check("drop.data", c_data, 16'h8000);

        // Mid-run reset at the second sample
        restart(1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst.wrreq", a_wr, 0);
        check("midrst.addr", a_addr, 0);
        check("midrst.sent_cnt", a_sent, 0);
        check("midrst.busy", a_busy, 0);
        rst = 1'b0;
        for (int i = 0; i < RW - 1; i++) step();
        check("midrst.rst_proc_before", a_rp, 0);
        step();
        check("midrst.rst_proc_again", a_rp, 1);

        // Random traffic; the 3-bit counter instance exercises saturation
        for (int i = 0; i < 3000; i++) begin
            pause   = ($urandom_range(0, 3) == 0);
            full    = ($urandom_range(0, 2) == 0);
            loop_en = ($urandom_range(0, 7) != 0);
            rst     = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
